// File: rtl/mcu_el2_ifu_fetch_sched_if.sv
// ---------------------------------------------------------------------------
// mcu_el2_ifu_fetch_sched_if
// Bundles the fetch scheduler's redirect, I-cache status, consume, stall and
// fetch-address signals. The slave modport is the scheduler; the master
// modport is whatever drives it (the surrounding IFU or a testbench).
//
// Signals (direction seen from the slave):
//   in : exu_flush_final, exu_flush_path_final[31:1], dec_tlu_flush_noredir_wb,
//        ic_hit_f, ifu_ic_mb_empty, ifu_bp_hit_taken_f,
//        ifu_bp_btb_target_f[31:1], ifu_fb_consume[CW-1:0], fetch_stall
//   out: ifc_fetch_addr_bf[31:1], ifc_fetch_req_bf, ifc_fetch_addr_f[31:1],
//        ifc_fetch_req_f, ifc_fb_count[CNTW-1:0], ifc_state[1:0],
//        ifu_pmu_fetch_stall, ifc_pf_req, ifc_pf_addr[31:1]
// ---------------------------------------------------------------------------
interface mcu_el2_ifu_fetch_sched_if #(
  parameter int unsigned FB_DEPTH    = 4,
  parameter int unsigned MAX_CONSUME = 2
);
  localparam int unsigned CW   = $clog2(MAX_CONSUME + 1);
  localparam int unsigned CNTW = $clog2(FB_DEPTH + 1);

  logic          exu_flush_final;
  logic [31:1]   exu_flush_path_final;
  logic          dec_tlu_flush_noredir_wb;
  logic          ic_hit_f;
  logic          ifu_ic_mb_empty;
  logic          ifu_bp_hit_taken_f;
  logic [31:1]   ifu_bp_btb_target_f;
  logic [CW-1:0] ifu_fb_consume;
  logic          fetch_stall;

  logic [31:1]     ifc_fetch_addr_bf;
  logic            ifc_fetch_req_bf;
  logic [31:1]     ifc_fetch_addr_f;
  logic            ifc_fetch_req_f;
  logic [CNTW-1:0] ifc_fb_count;
  logic [1:0]      ifc_state;
  logic            ifu_pmu_fetch_stall;
  logic            ifc_pf_req;
  logic [31:1]     ifc_pf_addr;

  modport slave (
    input  exu_flush_final, exu_flush_path_final, dec_tlu_flush_noredir_wb,
           ic_hit_f, ifu_ic_mb_empty, ifu_bp_hit_taken_f, ifu_bp_btb_target_f,
           ifu_fb_consume, fetch_stall,
    output ifc_fetch_addr_bf, ifc_fetch_req_bf, ifc_fetch_addr_f,
           ifc_fetch_req_f, ifc_fb_count, ifc_state, ifu_pmu_fetch_stall,
           ifc_pf_req, ifc_pf_addr
  );

  modport master (
    output exu_flush_final, exu_flush_path_final, dec_tlu_flush_noredir_wb,
           ic_hit_f, ifu_ic_mb_empty, ifu_bp_hit_taken_f, ifu_bp_btb_target_f,
           ifu_fb_consume, fetch_stall,
    input  ifc_fetch_addr_bf, ifc_fetch_req_bf, ifc_fetch_addr_f,
           ifc_fetch_req_f, ifc_fb_count, ifc_state, ifu_pmu_fetch_stall,
           ifc_pf_req, ifc_pf_addr
  );
endinterface

// File: rtl/mcu_el2_ifu_fetch_sched.sv
// ---------------------------------------------------------------------------
// mcu_el2_ifu_fetch_sched
// BF/F-stage fetch scheduler for the EL2 IFU. Picks the next fetch address
// (flush > replay > BTB target > sequential), throttles requests with a
// fetch-buffer credit counter, and tracks IDLE / FETCH / WFM (wait for miss).
//
// Ports:
//   clk    core clock
//   rst_l  asynchronous active-low reset
//   bus    mcu_el2_ifu_fetch_sched_if.slave (all fetch control/status)
//
// ifc_fetch_addr_bf, ifc_fetch_req_bf and ifu_pmu_fetch_stall are
// combinational; every other output comes straight from a flop.
//
// Optional feature: define MCU_IFC_NEXT_LINE_PF_EN to build the next-line
// prefetch hint (ifc_pf_req / ifc_pf_addr). Without it both are tied to 0.
// ---------------------------------------------------------------------------
module mcu_el2_ifu_fetch_sched #(
  parameter int unsigned FB_DEPTH         = 4,
  parameter int unsigned FETCH_BYTES_LOG2 = 2,
  parameter int unsigned LINE_BYTES_LOG2  = 6,
  parameter int unsigned MAX_CONSUME      = 2,
  parameter int unsigned CW               = $clog2(MAX_CONSUME + 1)
) (
  input logic                       clk,
  input logic                       rst_l,
  mcu_el2_ifu_fetch_sched_if.slave  bus
);

  localparam int unsigned CNTW  = $clog2(FB_DEPTH + 1);
  localparam int unsigned FB2   = FETCH_BYTES_LOG2;
  localparam int unsigned LB    = LINE_BYTES_LOG2;
  localparam int unsigned CALCW = ((CNTW > CW) ? CNTW : CW) + 1;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] FETCH = 2'b01;
  localparam logic [1:0] WFM   = 2'b11;

  logic [1:0]      state_q, state_d;
  logic [31:1]     addr_f_q, addr_bf;
  logic            req_f_q, req_bf;
  logic [CNTW-1:0] cnt_q, cnt_ns;
  logic            miss_a_q;

  logic            flush, noredir;
  logic            miss_f, wr_f;
  logic            active;
  logic [31:FB2]   seq_hi;
  logic [31:1]     seq_addr;
  logic [CALCW-1:0] cnt_sum;

  assign flush   = bus.exu_flush_final;
  assign noredir = bus.dec_tlu_flush_noredir_wb;

  // A flush cancels whatever F-stage fetch is in flight.
  assign miss_f = req_f_q & ~bus.ic_hit_f & ~flush;
  assign wr_f   = req_f_q &  bus.ic_hit_f & ~flush;

  // Sequential address: bump the fetch-granule index; crossing into a new
  // I-cache line restarts at the line's first halfword.
  always_comb begin
    seq_hi   = addr_f_q[31:FB2] + (32 - FB2)'(1);
    seq_addr = {seq_hi, addr_f_q[FB2-1:1]};
    if (seq_hi[LB] != addr_f_q[LB]) begin
      seq_addr[FB2-1:1] = '0;
    end
  end

  // BF address select and fetch-buffer credit update.
  always_comb begin
    addr_bf = seq_addr;
    cnt_ns  = '0;
    cnt_sum = CALCW'(cnt_q) + CALCW'(wr_f);

    if (flush) begin
      addr_bf = bus.exu_flush_path_final;
    end else if (~req_f_q | ~bus.ic_hit_f) begin
      addr_bf = addr_f_q;
    end else if (bus.ifu_bp_hit_taken_f) begin
      addr_bf = bus.ifu_bp_btb_target_f;
    end

    if (flush) begin
      cnt_ns = '0;
    end else if (CALCW'(bus.ifu_fb_consume) > cnt_sum) begin
      cnt_ns = '0;
    end else begin
      cnt_ns = CNTW'(cnt_sum - CALCW'(bus.ifu_fb_consume));
    end
  end

  // A redirecting flush seen while IDLE launches the first BF request in the
  // same cycle, so the redirect target is in F on the very next cycle.
  assign active = (state_q != IDLE) | flush;

  assign req_bf = active & (cnt_ns < CNTW'(FB_DEPTH)) &
                  ~bus.fetch_stall & ~noredir;

  // Next-state logic; a halt flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush & ~noredir) state_d = FETCH;
      end
      FETCH: begin
        if (miss_f) state_d = WFM;
      end
      WFM: begin
        if ((bus.ifu_ic_mb_empty | flush) & ~bus.fetch_stall &
            ~miss_f & ~miss_a_q) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush & noredir) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // F-stage flops: request, address, credit count and delayed miss.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      addr_f_q <= '0;
      req_f_q  <= 1'b0;
      cnt_q    <= '0;
      miss_a_q <= 1'b0;
    end else begin
      if (flush | req_f_q) addr_f_q <= addr_bf;
      req_f_q  <= req_bf;
      cnt_q    <= cnt_ns;
      miss_a_q <= miss_f;
    end
  end

`ifdef MCU_IFC_NEXT_LINE_PF_EN
  logic          pf_req_q;
  logic [31:1]   pf_addr_q;
  logic          pf_fire;
  logic [31:LB]  pf_line;

  // Only the miss that moves FETCH into WFM hints the following line.
  assign pf_fire = miss_f & ~noredir & (state_q == FETCH);
  assign pf_line = addr_f_q[31:LB] + (32 - LB)'(1);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pf_req_q  <= 1'b0;
      pf_addr_q <= '0;
    end else begin
      pf_req_q <= pf_fire;
      if (pf_fire) pf_addr_q <= {pf_line, (LB - 1)'(0)};
    end
  end

  assign bus.ifc_pf_req  = pf_req_q;
  assign bus.ifc_pf_addr = pf_addr_q;
`else
  assign bus.ifc_pf_req  = 1'b0;
  assign bus.ifc_pf_addr = '0;
`endif

  assign bus.ifc_fetch_addr_bf   = addr_bf;
  assign bus.ifc_fetch_req_bf    = req_bf;
  assign bus.ifc_fetch_addr_f    = addr_f_q;
  assign bus.ifc_fetch_req_f     = req_f_q;
  assign bus.ifc_fb_count        = cnt_q;
  assign bus.ifc_state           = state_q;
  assign bus.ifu_pmu_fetch_stall =
      (state_q == WFM) |
      ((state_q != IDLE) &
       (((cnt_q == CNTW'(FB_DEPTH)) & (bus.ifu_fb_consume == '0) & ~flush) |
        bus.fetch_stall));

endmodule
